// File: rtl/image_write_sequencer.sv
`timescale 1ns/1ps
// image_write_sequencer
// Buffers pixel pairs from the processing pipeline in a small FIFO and
// replays them to the BMP writer as one-cycle hsync strobes. A blanking gap
// follows every row. The block stops after exactly one frame, pulses
// frame_done and returns to idle.
module image_write_sequencer #(
    parameter int WIDTH      = 384,
    parameter int HEIGHT     = 256,
    parameter int HBLANK     = 4,
    parameter int FIFO_DEPTH = 4,
    localparam int ROW_W     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int COL_W     = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_R0,
    input  logic [7:0]       in_G0,
    input  logic [7:0]       in_B0,
    input  logic [7:0]       in_R1,
    input  logic [7:0]       in_G1,
    input  logic [7:0]       in_B1,
    output logic             hsync,
    output logic [7:0]       DATA_WRITE_R0,
    output logic [7:0]       DATA_WRITE_G0,
    output logic [7:0]       DATA_WRITE_B0,
    output logic [7:0]       DATA_WRITE_R1,
    output logic [7:0]       DATA_WRITE_G1,
    output logic [7:0]       DATA_WRITE_B1,
    output logic             busy,
    output logic             frame_done,
    output logic [ROW_W-1:0] row_idx,
    output logic [COL_W-1:0] col_idx
);

    localparam int PAIRS_PER_ROW = WIDTH / 2;
    localparam int TOTAL_PAIRS   = (WIDTH * HEIGHT) / 2;
    localparam int PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W         = PTR_W + 1;
    localparam int ACC_W         = $clog2(TOTAL_PAIRS + 1);
    localparam int BLK_W         = (HBLANK > 0) ? $clog2(HBLANK + 1) : 1;

    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(PAIRS_PER_ROW - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(HEIGHT - 1);
    localparam logic [BLK_W-1:0] BLANK_LOAD = BLK_W'(HBLANK);
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ACC_W-1:0] TOTAL_CNT  = ACC_W'(TOTAL_PAIRS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             fsm_next_s;
    state_t             next_state_s;
    logic               fsm_pop_s;
    logic               fsm_load_blank_s;
    logic               pop_s;
    logic               push_s;
    logic               load_blank_s;
    logic               clear_s;

    logic [47:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [ACC_W-1:0]   acc_r;
    logic [COL_W-1:0]   col_r;
    logic [ROW_W-1:0]   row_r;
    logic [BLK_W-1:0]   blank_r;

    logic [47:0]        in_pair_s;
    logic [47:0]        data_r;
    logic               hsync_r;
    logic               busy_r;
    logic               frame_done_r;

    assign in_pair_s = {in_R0, in_G0, in_B0, in_R1, in_G1, in_B1};

    // in_ready is a pure function of registered state, so it carries no
    // combinational path from any input.
    assign in_ready = ((state_r == ST_ACTIVE) || (state_r == ST_HBLANK))
                      && (count_r < DEPTH_CNT)
                      && (acc_r < TOTAL_CNT);
    assign push_s   = in_valid & in_ready;

    // A new frame and an abort both flush the FIFO and zero every counter.
    assign clear_s  = abort | ((state_r == ST_IDLE) & start);

    // Next-state and pop decision; abort overrides everything below.
    always_comb begin
        fsm_next_s       = state_r;
        fsm_pop_s        = 1'b0;
        fsm_load_blank_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    fsm_next_s = ST_ACTIVE;
                end else begin
                    fsm_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (count_r != '0) begin
                    fsm_pop_s = 1'b1;
                    if (col_r == LAST_COL) begin
                        if (row_r == LAST_ROW) begin
                            fsm_next_s = ST_DONE;
                        end else if (HBLANK > 0) begin
                            fsm_next_s       = ST_HBLANK;
                            fsm_load_blank_s = 1'b1;
                        end else begin
                            fsm_next_s = ST_ACTIVE;
                        end
                    end else begin
                        fsm_next_s = ST_ACTIVE;
                    end
                end else begin
                    fsm_next_s = ST_ACTIVE;
                end
            end
            ST_HBLANK: begin
                if (blank_r <= BLK_W'(1)) begin
                    fsm_next_s = ST_ACTIVE;
                end else begin
                    fsm_next_s = ST_HBLANK;
                end
            end
            ST_DONE: begin
                fsm_next_s = ST_IDLE;
            end
            default: begin
                fsm_next_s = ST_IDLE;
            end
        endcase
    end

    assign next_state_s = abort ? ST_IDLE : fsm_next_s;
    assign pop_s        = fsm_pop_s & ~abort;
    assign load_blank_s = fsm_load_blank_s & ~abort;

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clear_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; a flush only moves the pointers, stale entries are never read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_pair_s;
        end
    end

    // Frame position counters and the row blanking down-counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            acc_r   <= '0;
            col_r   <= '0;
            row_r   <= '0;
            blank_r <= '0;
        end else if (clear_s) begin
            acc_r   <= '0;
            col_r   <= '0;
            row_r   <= '0;
            blank_r <= '0;
        end else begin
            if (push_s) begin
                acc_r <= acc_r + 1'b1;
            end
            if (pop_s) begin
                if (col_r == LAST_COL) begin
                    col_r <= '0;
                    row_r <= row_r + 1'b1;
                end else begin
                    col_r <= col_r + 1'b1;
                end
            end
            if (load_blank_s) begin
                blank_r <= BLANK_LOAD;
            end else if ((state_r == ST_HBLANK) && (blank_r != '0)) begin
                blank_r <= blank_r - 1'b1;
            end
        end
    end

    // Writer-facing pair register; holds its value until the next strobe.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_r <= '0;
        end else if (pop_s) begin
            data_r <= mem_r[rd_ptr_r];
        end
    end

    // Registered strobes and status; frame_done follows the DONE cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else if (abort) begin
            hsync_r      <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            hsync_r      <= pop_s;
            busy_r       <= (next_state_s != ST_IDLE);
            frame_done_r <= (state_r == ST_DONE);
        end
    end

    assign hsync         = hsync_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign row_idx       = row_r;
    assign col_idx       = col_r;
    assign DATA_WRITE_R0 = data_r[47:40];
    assign DATA_WRITE_G0 = data_r[39:32];
    assign DATA_WRITE_B0 = data_r[31:24];
    assign DATA_WRITE_R1 = data_r[23:16];
    assign DATA_WRITE_G1 = data_r[15:8];
    assign DATA_WRITE_B1 = data_r[7:0];

endmodule

// File: doc/image_write_sequencer.md
# image_write_sequencer

Frame sequencer that sits between the pixel-processing pipeline and the BMP `image_write` capture block. It accepts pixel pairs from the upstream stage over a valid/ready handshake and buffers them in a small FIFO. It replays them to the writer as one-cycle `hsync` strobes, inserting a programmable blanking gap after every row. It stops after exactly one frame, pulses `frame_done`, and returns to idle, so the writer never sees extra or missing pairs.

## Interface
- `WIDTH`, 384, image width in pixels; must be even.
- `HEIGHT`, 256, image height in rows.
- `HBLANK`, 4, idle cycles inserted after each row's last strobe; 0 means no gap.
- `FIFO_DEPTH`, 4, pixel-pair buffer entries; power of 2, ≥ 2.
- `HCLK` in 1: the single clock; all logic on its rising edge.
- `HRESETn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that begins a frame; ignored unless IDLE.
- `abort` in 1: level; flushes the block and returns it to IDLE.
- `in_valid` in 1: upstream pair valid.
- `in_ready` out 1: block can accept a pair this cycle.
- `in_R0`, `in_G0`, `in_B0`, `in_R1`, `in_G1`, `in_B1` in 8 each: pixel pair, pixel 0 first.
- `hsync` out 1: one-cycle strobe, one per pair, to the writer.
- `DATA_WRITE_R0`, `DATA_WRITE_G0`, `DATA_WRITE_B0`, `DATA_WRITE_R1`, `DATA_WRITE_G1`, `DATA_WRITE_B1` out 8 each: registered pair; held until the next strobe.
- `busy` out 1: high in ACTIVE, HBLANK and DONE.
- `frame_done` out 1: one-cycle pulse at frame end.
- `row_idx` out clog2(HEIGHT): rows completed.
- `col_idx` out clog2(WIDTH/2): pairs emitted in the current row.

## Operation
- **Reset values.** All outputs are 0; the FSM is in IDLE; the FIFO is empty; all counters are 0.
- **FSM states.** IDLE, ACTIVE, HBLANK, DONE.
- **IDLE.**
  - `in_ready` is 0 and `hsync` is 0.
  - `start` moves the FSM to ACTIVE.
  - Entering ACTIVE clears all counters and the FIFO.
- **Accept rule.** `in_ready` = (state is ACTIVE or HBLANK) AND (FIFO count < FIFO_DEPTH) AND (accepted count < WIDTH*HEIGHT/2).
  - A push occurs when `in_valid` and `in_ready` are both high.
  - After the last pair of the frame is accepted, `in_ready` stays 0 until the next frame.
- **ACTIVE.**
  - On every cycle where the FIFO is non-empty, pop one entry.
  - The pop registers the pair onto the DATA_WRITE outputs and sets `hsync` = 1 for one cycle.
  - `col_idx` increments on each pop.
  - A pop with `col_idx` = WIDTH/2−1 is the row's last pair:
    - `col_idx` wraps to 0 and `row_idx` increments.
    - If this was row HEIGHT−1, go to DONE.
    - Otherwise, if HBLANK > 0, go to HBLANK; if HBLANK = 0, stay in ACTIVE.
- **HBLANK.**
  - No pops occur; pushes continue.
  - A down-counter loaded with HBLANK returns the FSM to ACTIVE after exactly HBLANK cycles.
- **DONE.**
  - `frame_done` = 1 for one cycle, then go to IDLE.
  - `busy` falls on entry to IDLE.
- **Push and pop in the same cycle.** Both may occur; the FIFO count is unchanged.
- **abort.**
  - Valid in any state; takes priority over `start` and over a pending pop.
  - On the next edge: state is IDLE, FIFO is empty, counters are 0, `hsync` is 0.
  - No `frame_done` is generated.
- **start while busy.** Ignored; it does not restart the frame.
- **Reset mid-frame.** Immediate return to the reset values.
- **Pair order.** Pairs reach `hsync` in acceptance order, with no duplication and no loss.

## Timing
- **Latency.** A pair accepted on edge k, into an empty FIFO in ACTIVE, produces `hsync` = 1 during the cycle after edge k+1. This is one bubble of latency.
- **Throughput.** At most one strobe per cycle; strobes on consecutive cycles are allowed.
- **Writer contract.** The writer samples data on the edge where `hsync` is high. Data is registered, so it is stable for that whole cycle.
- **Row gap.** After each row's last strobe there are exactly HBLANK cycles with `hsync` = 0 before the next row's first strobe can appear.
- **Frame end.** `frame_done` is high in the cycle immediately after the frame's final strobe cycle.
- **Strobe count.** Exactly WIDTH*HEIGHT/2 strobes per frame.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, HBLANK=2, FIFO_DEPTH=4, unless a scenario states otherwise.
- **Reset.** Hold `HRESETn` low -> all outputs 0; after release, `in_ready` = 0 until `start`.
- **Continuous frame.** `start`, then `in_valid` held high with incrementing pair data -> exactly 16 strobes in 4 groups of 4. Each group is separated by 2 idle cycles. Data matches input order. `frame_done` pulses once after strobe 16. `in_ready` is 0 after the 16th accept.
- **Backpressure.** FIFO_DEPTH=2, HBLANK=4, continuous `in_valid` -> `in_ready` drops during HBLANK once 2 pairs are buffered, with no pair lost. Then drive random `in_valid` gaps -> strobes follow the gaps, with order preserved and no duplicates.
- **abort.** Assert `abort` after row 1, pair 2 -> next edge: IDLE, `hsync` 0, `row_idx` = `col_idx` = 0, no `frame_done`. A following `start` produces a fresh, complete 16-strobe frame.
- **start ignored.** `start` pulses mid-frame -> strobe count and `row_idx` unaffected; still a single `frame_done`.
- **Async reset mid-frame.** Pull `HRESETn` low between clock edges -> outputs go to 0 without waiting for an edge.
